// File: rtl/prio_encoder_scan.sv
// Registered priority scanner: accepts an N-bit request bitmap and emits the index
// of each set bit in priority order, one per output handshake.
module prio_encoder_scan #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int W        = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] In,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] O,
  output logic         out_last,
  output logic         zero_in
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t       state, state_nxt;
  logic [N-1:0] bitmap, bitmap_nxt;
  logic [W-1:0] pick_idx;
  logic [N-1:0] pick_oh;
  logic         single;
  logic         zero_nxt;

  // Later iterations overwrite earlier ones, so the scan order decides priority.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (bitmap[MSB_FIRST ? i : N-1-i]) pick_idx = W'(MSB_FIRST ? i : N-1-i);
    end
    pick_oh = N'(1) << pick_idx;
  end

  assign single    = ((bitmap & (bitmap - N'(1))) == '0);
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == SCAN);
  assign O         = out_valid ? pick_idx : '0;
  assign out_last  = out_valid && single;

  always_comb begin
    state_nxt  = state;
    bitmap_nxt = bitmap;
    zero_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          if (|In) begin
            bitmap_nxt = In;
            state_nxt  = SCAN;
          end else begin
            zero_nxt = 1'b1;
          end
        end
      end
      SCAN: begin
        if (out_ready) begin
          bitmap_nxt = bitmap & ~pick_oh;
          if (single) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bitmap  <= '0;
      zero_in <= 1'b0;
    end else begin
      state   <= state_nxt;
      bitmap  <= bitmap_nxt;
      zero_in <= zero_nxt;
    end
  end

endmodule

// File: tb/tb_prio_encoder_scan.sv
// Bench for prio_encoder_scan: three instances (N=8 MSB-first, N=8 LSB-first,
// N=16 MSB-first) driven by directed steps against a queue of expected beats.
module tb_prio_encoder_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv   [3];
  logic [15:0] ib   [3];
  logic        ordy [3];
  logic        ir   [3];
  logic        ov   [3];
  logic        ol   [3];
  logic        zi   [3];
  logic [2:0]  o_msb, o_lsb;
  logic [3:0]  o_w16;

  typedef struct {integer idx; integer last;} beat_t;
  beat_t exp_q[$];

  integer checks = 0;
  integer errors = 0;

  always #5 clk = ~clk;

  prio_encoder_scan #(.N(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .In(ib[0][7:0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .O(o_msb), .out_last(ol[0]), .zero_in(zi[0]));

  prio_encoder_scan #(.N(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .In(ib[1][7:0]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .O(o_lsb), .out_last(ol[1]), .zero_in(zi[1]));

  prio_encoder_scan #(.N(16), .MSB_FIRST(1'b1)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .In(ib[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .O(o_w16), .out_last(ol[2]), .zero_in(zi[2]));

  function automatic integer f_o(int d);
    case (d)
      0:       return integer'(o_msb);
      1:       return integer'(o_lsb);
      default: return integer'(o_w16);
    endcase
  endfunction

  task automatic chk(string tag, integer obs, integer exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference order: walk the bitmap and emit set indices in the instance's priority order.
  task automatic push_exp(int d, logic [15:0] bm);
    int n;
    int idxs[$];
    n = (d == 2) ? 16 : 8;
    for (int i = 0; i < n; i++) begin
      if (bm[i]) begin
        if (d == 1) idxs.push_back(i);
        else        idxs.push_front(i);
      end
    end
    for (int k = 0; k < idxs.size(); k++)
      exp_q.push_back('{idx: idxs[k], last: (k == idxs.size() - 1) ? 1 : 0});
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(int d, logic [15:0] bm);
    chk("send_in_ready", integer'(ir[d]), 1);
    iv[d] = 1'b1;
    ib[d] = bm;
    @(negedge clk);
    iv[d] = 1'b0;
    ib[d] = ~bm;
    push_exp(d, bm);
  endtask

  task automatic drain(int d, int maxb, output int ncyc);
    int    beats;
    beat_t e;
    beats   = 0;
    ncyc    = 0;
    ordy[d] = 1'b1;
    while (exp_q.size() > 0 && beats < maxb && ncyc < 64) begin
      ncyc++;
      chk("out_valid", integer'(ov[d]), 1);
      if (ov[d] === 1'b1) begin
        e = exp_q.pop_front();
        chk("O", f_o(d), e.idx);
        chk("out_last", integer'(ol[d]), e.last);
        beats++;
      end
      @(negedge clk);
    end
    if (beats < maxb) chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic idle_after(int d, string tag);
    chk({tag, "_out_valid"}, integer'(ov[d]), 0);
    chk({tag, "_in_ready"}, integer'(ir[d]), 1);
    chk({tag, "_O"}, f_o(d), 0);
  endtask

  initial begin
    int n;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; ib[d] = '0; ordy[d] = 1'b1;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_out_valid", integer'(ov[d]), 0);
      chk("rst_O", f_o(d), 0);
      chk("rst_out_last", integer'(ol[d]), 0);
      chk("rst_zero_in", integer'(zi[d]), 0);
      chk("rst_in_ready", integer'(ir[d]), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) idle_after(d, "post_rst");

    // MSB-first drain of 1010_0110
    send(0, 16'h00A6);
    drain(0, 99, n);
    chk("t1_cycles", n, 4);
    idle_after(0, "t1_idle");

    // LSB-first drain of the same bitmap
    send(1, 16'h00A6);
    drain(1, 99, n);
    chk("t2_cycles", n, 4);
    idle_after(1, "t2_idle");

    // Backpressure holds the current beat
    ordy[0] = 1'b0;
    send(0, 16'h00C0);
    repeat (3) begin
      chk("t3_hold_valid", integer'(ov[0]), 1);
      chk("t3_hold_O", f_o(0), 7);
      chk("t3_hold_last", integer'(ol[0]), 0);
      chk("t3_hold_in_ready", integer'(ir[0]), 0);
      @(negedge clk);
    end
    drain(0, 99, n);
    chk("t3_cycles", n, 2);
    idle_after(0, "t3_idle");

    // All-zero bitmap is dropped with a single zero_in pulse
    send(0, 16'h0000);
    chk("t4_zero_pulse", integer'(zi[0]), 1);
    chk("t4_out_valid", integer'(ov[0]), 0);
    chk("t4_in_ready", integer'(ir[0]), 1);
    @(negedge clk);
    chk("t4_zero_clear", integer'(zi[0]), 0);
    chk("t4_out_valid2", integer'(ov[0]), 0);

    // Reset mid-scan discards the rest of 0xA5; in_valid during reset is ignored
    send(0, 16'h00A5);
    drain(0, 2, n);
    chk("t5_third_O", f_o(0), 2);
    rst   = 1'b1;
    iv[0] = 1'b1;
    ib[0] = 16'h00FF;
    @(negedge clk);
    chk("t5_rst_out_valid", integer'(ov[0]), 0);
    chk("t5_rst_O", f_o(0), 0);
    chk("t5_rst_last", integer'(ol[0]), 0);
    chk("t5_rst_in_ready", integer'(ir[0]), 0);
    rst   = 1'b0;
    iv[0] = 1'b0;
    @(negedge clk);
    idle_after(0, "t5_after");
    repeat (3) begin
      @(negedge clk);
      chk("t5_no_beats", integer'(ov[0]), 0);
    end
    exp_q.delete();

    // N=16: top index and a single-bit bitmap
    send(2, 16'h8001);
    drain(2, 99, n);
    chk("t6_cycles", n, 2);
    idle_after(2, "t6_idle");
    send(2, 16'h0008);
    drain(2, 99, n);
    chk("t6_single_cycles", n, 1);
    idle_after(2, "t6_single_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
